ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder: the slave endpoint on one AHB_bus slave port (slave_N_in/_out pair).
//  Backs a byte-addressable SRAM window and inserts a programmable number of wait states.
//  Returns the two-cycle ERROR response for illegal accesses. Used as the bus
//  bring-up target and as the default memory model in bus-level benches.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  first byte address decoded by this slave
//  MEM_BYTES    1024           window size in bytes; power of 2, >=4
//  WAIT_STATES  1              hreadyout=0 cycles per OKAY data phase; 0..15
// PORTS
//  hclk       in   1   bus clock, all state on rising edge
//  hreset     in   1   synchronous, active-high reset
//  hsel       in   1   slave select from bus decoder
//  haddr      in   32  address-phase byte address
//  htrans     in   2   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  hwrite     in   1   1=write
//  hsize      in   3   0=byte 1=half 2=word; >2 illegal
//  hburst     in   3   informational only; each beat is decoded independently
//  hwdata     in   32  write data, valid in data phase
//  hready     in   1   bus-level ready (mux of all slaves' hreadyout)
//  hreadyout  out  1   this slave's ready
//  hresp      out  1   0=OKAY 1=ERROR
//  hrdata     out  32  read data, valid when hreadyout=1 in a read data phase
// BEHAVIOUR
//  Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. SRAM is not cleared.
//  Address phase accepted only when hsel&&hready&&htrans[1]. Capture haddr, hwrite, hsize.
//  IDLE/BUSY or hsel=0 with hready=1: no transfer, next cycle OKAY zero-wait.
//  Legality check at capture: hsize<=2; address aligned to size; BASE_ADDR<=haddr<BASE_ADDR+MEM_BYTES.
//  FSM states:
//   IDLE  - no data phase pending.
//           Legal capture with WAIT_STATES>0 -> WAIT; with WAIT_STATES=0 -> DATA.
//           Illegal capture -> ERR1.
//   WAIT  - hreadyout=0, hresp=0; counter counts to WAIT_STATES-1, then -> DATA.
//   DATA  - hreadyout=1, hresp=0.
//           Write: byte lanes of hwdata are committed this edge.
//           Read: hrdata = mem word at the captured address.
//           A new capture this cycle follows the IDLE rules; otherwise -> IDLE.
//   ERR1  - hreadyout=0, hresp=1 -> ERR2.
//   ERR2  - hreadyout=1, hresp=1. A new capture may occur here (same rules as IDLE).
//  Byte lanes (little-endian, word = addr[..:2]):
//   hsize=0: lane addr[1:0].  hsize=1: lanes {addr[1],0}..+1.  hsize=2: all four lanes.
//  Reads return the full word; unaddressed lanes carry real memory contents.
//  hrdata=0 outside a read DATA cycle.
//  Back-to-back: a capture in DATA/ERR2 (hready=1) starts the next data phase with no bubble.
//  Write->read of the same address is back-to-back safe: the write commits before the read's data phase.
//  An ERROR transfer never modifies memory.
//  A master dropping the burst to IDLE after ERR2 is tolerated; no state is leaked.
//  hreset asserted mid-transfer: next edge forces the reset values.
//   Any pending write is dropped (not committed).
//  Address wrap: offsets are haddr-BASE_ADDR; out-of-window accesses are ERROR, never aliased.
// STRUCTURE
//  AHB_package gains:
//   htrans_e {IDLE,BUSY,NONSEQ,SEQ}; hresp_e {OKAY,ERROR}; hsize_e {BYTE,HALF,WORD}
//   function ahb_lane_mask(hsize, addr[1:0]) -> logic [3:0]
//  Sub-module ahb_sram_mem: MEM_BYTES/4 x 32 array with 4-bit byte-enable write and combinational read.
//  FSM, capture registers, wait counter and legality check live in the top module.
// TESTING
//  Reset: hreset=1 for 2 cycles -> hreadyout=1, hresp=0, hrdata=0.
//  WAIT_STATES=1: write word 0x10=DEADBEEF, then read 0x10.
//   -> each data phase has 1 low cycle; read returns DEADBEEF.
//  Byte write 0x13=0xAA after the word above; read 0x10 -> AADEBEEF.
//   Half write 0x10=0x1234 -> read returns AADE1234.
//  WAIT_STATES=0: INCR4 write 0x20..0x2C, then back-to-back read burst.
//   -> hreadyout stays 1 throughout; data matches.
//   Write 0x40 immediately followed by read 0x40 -> new value returned.
//  Illegal accesses, one each:
//   haddr=BASE_ADDR+MEM_BYTES; haddr=0x02 with hsize=2; hsize=3
//   -> hresp=1 for exactly 2 cycles, hreadyout 0 then 1; memory unchanged on readback.
//  Assert hreset during WAIT of a write to 0x50 (old 0x11111111).
//   -> outputs reset next cycle; readback 0x50=0x11111111.
//   hsel=0 traffic to other slaves -> this slave stays hreadyout=1, hresp=0.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types and the byte-lane helper used by the SRAM responder.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  // Data-phase progress of the responder.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Little-endian byte lanes touched by a transfer of the given size at addr[1:0].
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] hsize,
                                               input logic [1:0] addr);
    logic [3:0] mask;
    case (hsize)
      SIZE_BYTE: mask = 4'b0001 << addr;
      SIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
module ahb_sram_slave_mem #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];

  // Commit the enabled byte lanes of the write word.
  // NOTE: the array has no reset branch; contents deliberately survive hreset and a clear would need a per-word sweep.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: address decode, legality check, wait-state insertion
// and the two-cycle ERROR response in front of a byte-enabled SRAM.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int unsigned AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam logic [31:0] WINDOW    = 32'(MEM_BYTES);

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic          write_q, write_d;

  logic [32:0]   diff;
  logic [31:0]   offset;
  logic          in_window, aligned, legal, capture;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  // Burst type is informational and htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, htrans[0]};

  // A 33-bit subtraction exposes the borrow, so addresses below the window never wrap into it.
  assign diff      = {1'b0, haddr} - {1'b0, BASE_ADDR};
  assign offset    = diff[31:0];
  assign in_window = !diff[32] && (offset < WINDOW);
  assign capture   = hsel && hready && htrans[1];
  assign legal     = aligned && in_window;

  // Alignment for each legal size; sizes above a word are never aligned.
  always_comb begin
    case (hsize)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = !haddr[0];
      SIZE_WORD: aligned = (haddr[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
  end

  // Next-state logic: accept a new address phase in IDLE/DATA/ERR2, count waits, sequence errors.
  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    write_d    = write_q;
    unique case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_DATA;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (capture) begin
          addr_d     = offset[AW+1:2];
          be_d       = ahb_lane_mask(hsize, haddr[1:0]);
          write_d    = hwrite;
          wait_cnt_d = 4'd0;
          if (!legal)                state_d = ST_ERR1;
          else if (WAIT_STATES != 0) state_d = ST_WAIT;
          else                       state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      write_q    <= write_d;
    end
  end

  // A write commits on the edge that ends its DATA cycle, unless reset lands on that edge.
  assign mem_we = (state_q == ST_DATA) && write_q && !hreset;

  ahb_sram_slave_mem #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_mem (
    .clk_i   (hclk),
    .we_i    (mem_we),
    .be_i    (be_q),
    .addr_i  (addr_q),
    .wdata_i (hwdata),
    .rdata_o (mem_rdata)
  );

  assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem_rdata : 32'h0;

endmodule
